// File: rtl/axilite_write_arbiter.sv
// axilite_write_arbiter: round-robin sharing of one AXI-Lite write master
// (AW/W/B) among NUM_REQ requesters, one transaction in flight at a time.
module axilite_write_arbiter #(
    parameter int NUM_REQ            = 4,
    parameter int AXILITE_ADDR_WIDTH = 64,
    parameter int AXILITE_DATA_WIDTH = 64
) (
    input  logic                                  i_clk,
    input  logic                                  i_rst_n,
    input  logic [NUM_REQ-1:0]                    i_req_valid,
    input  logic [NUM_REQ*AXILITE_ADDR_WIDTH-1:0] i_req_addr,
    input  logic [NUM_REQ*AXILITE_DATA_WIDTH-1:0] i_req_data,
    output logic [NUM_REQ-1:0]                    o_req_done,
    output logic                                  o_req_err,
    output logic                                  o_busy,
    output logic [2:0]                            o_grant_id,
    output logic [AXILITE_ADDR_WIDTH-1:0]         o_m_axi_awaddr,
    output logic                                  o_m_axi_awvalid,
    input  logic                                  i_m_axi_awready,
    output logic [AXILITE_DATA_WIDTH-1:0]         o_m_axi_wdata,
    output logic [AXILITE_DATA_WIDTH/8-1:0]       o_m_axi_wstrb,
    output logic                                  o_m_axi_wvalid,
    input  logic                                  i_m_axi_wready,
    input  logic [1:0]                            i_m_axi_bresp,
    input  logic                                  i_m_axi_bvalid,
    output logic                                  o_m_axi_bready
);

    localparam int STRB_W = AXILITE_DATA_WIDTH / 8;

    typedef enum logic [1:0] {IDLE, ISSUE, RESP, DONE} state_t;

    state_t                          r_state;
    logic [2:0]                      r_last_grant;
    logic [2:0]                      r_grant_id;
    logic [AXILITE_ADDR_WIDTH-1:0]   r_awaddr;
    logic [AXILITE_DATA_WIDTH-1:0]   r_wdata;
    logic                            r_awvalid;
    logic                            r_wvalid;
    logic                            r_aw_done;
    logic                            r_w_done;
    logic                            r_bready;
    logic [NUM_REQ-1:0]              r_req_done;
    logic                            r_req_err;
    logic                            r_busy;

    logic [NUM_REQ-1:0][AXILITE_ADDR_WIDTH-1:0] w_addr;
    logic [NUM_REQ-1:0][AXILITE_DATA_WIDTH-1:0] w_data;
    logic                            w_any;
    logic [2:0]                      w_winner;
    logic [AXILITE_ADDR_WIDTH-1:0]   w_sel_addr;
    logic [AXILITE_DATA_WIDTH-1:0]   w_sel_data;
    logic                            w_aw_fire;
    logic                            w_w_fire;
    logic [NUM_REQ-1:0]              w_grant_oh;
    logic                            w_unused_bresp0;

    // Unpack the flat request buses into per-requester slices
    genvar g;
    generate
        for (g = 0; g < NUM_REQ; g++) begin : g_slice
            assign w_addr[g] = i_req_addr[g*AXILITE_ADDR_WIDTH +: AXILITE_ADDR_WIDTH];
            assign w_data[g] = i_req_data[g*AXILITE_DATA_WIDTH +: AXILITE_DATA_WIDTH];
        end
    endgenerate

    // Round-robin pick: first requester found searching upward from last_grant+1
    always_comb begin
        int idx;
        w_any      = 1'b0;
        w_winner   = '0;
        w_sel_addr = '0;
        w_sel_data = '0;
        idx        = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = (int'(r_last_grant) + k) % NUM_REQ;
            if (!w_any && i_req_valid[idx]) begin
                w_any      = 1'b1;
                w_winner   = 3'(idx);
                w_sel_addr = w_addr[idx];
                w_sel_data = w_data[idx];
            end
        end
    end

    assign w_aw_fire       = r_awvalid & i_m_axi_awready;
    assign w_w_fire        = r_wvalid & i_m_axi_wready;
    assign w_grant_oh      = NUM_REQ'(1) << r_grant_id;
    // Only bresp[1] distinguishes error from OKAY/EXOKAY
    assign w_unused_bresp0 = i_m_axi_bresp[0];

    // Transaction FSM; every output is a register updated here
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state      <= IDLE;
            r_last_grant <= 3'(NUM_REQ - 1);
            r_grant_id   <= '0;
            r_awaddr     <= '0;
            r_wdata      <= '0;
            r_awvalid    <= 1'b0;
            r_wvalid     <= 1'b0;
            r_aw_done    <= 1'b0;
            r_w_done     <= 1'b0;
            r_bready     <= 1'b0;
            r_req_done   <= '0;
            r_req_err    <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_any) begin
                        r_grant_id   <= w_winner;
                        r_last_grant <= w_winner;
                        r_awaddr     <= w_sel_addr;
                        r_wdata      <= w_sel_data;
                        r_awvalid    <= 1'b1;
                        r_wvalid     <= 1'b1;
                        r_aw_done    <= 1'b0;
                        r_w_done     <= 1'b0;
                        r_busy       <= 1'b1;
                        r_state      <= ISSUE;
                    end
                end
                ISSUE: begin
                    // AW and W handshake independently; neither is re-raised
                    if (w_aw_fire) begin
                        r_awvalid <= 1'b0;
                        r_aw_done <= 1'b1;
                    end
                    if (w_w_fire) begin
                        r_wvalid <= 1'b0;
                        r_w_done <= 1'b1;
                    end
                    if ((r_aw_done || w_aw_fire) && (r_w_done || w_w_fire)) begin
                        r_bready <= 1'b1;
                        r_state  <= RESP;
                    end
                end
                RESP: begin
                    if (i_m_axi_bvalid && r_bready) begin
                        r_bready   <= 1'b0;
                        r_req_err  <= i_m_axi_bresp[1];
                        r_req_done <= w_grant_oh;
                        r_state    <= DONE;
                    end
                end
                DONE: begin
                    // Completion pulse lasts exactly the DONE cycle
                    r_req_done <= '0;
                    r_req_err  <= 1'b0;
                    r_busy     <= 1'b0;
                    r_state    <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign o_req_done      = r_req_done;
    assign o_req_err       = r_req_err;
    assign o_busy          = r_busy;
    assign o_grant_id      = r_grant_id;
    assign o_m_axi_awaddr  = r_awaddr;
    assign o_m_axi_awvalid = r_awvalid;
    assign o_m_axi_wdata   = r_wdata;
    assign o_m_axi_wstrb   = {STRB_W{1'b1}};
    assign o_m_axi_wvalid  = r_wvalid;
    assign o_m_axi_bready  = r_bready;

endmodule

// File: tb/tb_axilite_write_arbiter.sv
// Directed self-checking bench for axilite_write_arbiter.
module tb_axilite_write_arbiter;

    localparam int N  = 4;
    localparam int AW = 64;
    localparam int DW = 64;

    logic            clk;
    logic            rst_n;
    logic [N-1:0]    req_valid;
    logic [N*AW-1:0] req_addr;
    logic [N*DW-1:0] req_data;
    logic [N-1:0]    req_done;
    logic            req_err;
    logic            busy;
    logic [2:0]      grant_id;
    logic [AW-1:0]   awaddr;
    logic            awvalid;
    logic            awready;
    logic [DW-1:0]   wdata;
    logic [DW/8-1:0] wstrb;
    logic            wvalid;
    logic            wready;
    logic [1:0]      bresp;
    logic            bvalid;
    logic            bready;

    int n_tests = 0;
    int n_fail  = 0;

    axilite_write_arbiter #(
        .NUM_REQ(N), .AXILITE_ADDR_WIDTH(AW), .AXILITE_DATA_WIDTH(DW)
    ) dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_req_valid(req_valid), .i_req_addr(req_addr), .i_req_data(req_data),
        .o_req_done(req_done), .o_req_err(req_err), .o_busy(busy), .o_grant_id(grant_id),
        .o_m_axi_awaddr(awaddr), .o_m_axi_awvalid(awvalid), .i_m_axi_awready(awready),
        .o_m_axi_wdata(wdata), .o_m_axi_wstrb(wstrb), .o_m_axi_wvalid(wvalid),
        .i_m_axi_wready(wready), .i_m_axi_bresp(bresp), .i_m_axi_bvalid(bvalid),
        .o_m_axi_bready(bready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one cycle and land 1ns after the rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        #12;
        n_tests++; if (awvalid !== 1'b0) begin n_fail++; $display("FAIL rst_awvalid: got %0h want 0", awvalid); end
        n_tests++; if (wvalid !== 1'b0) begin n_fail++; $display("FAIL rst_wvalid: got %0h want 0", wvalid); end
        n_tests++; if (bready !== 1'b0) begin n_fail++; $display("FAIL rst_bready: got %0h want 0", bready); end
        n_tests++; if (req_done !== 4'b0000) begin n_fail++; $display("FAIL rst_req_done: got %b want 0000", req_done); end
        n_tests++; if (req_err !== 1'b0) begin n_fail++; $display("FAIL rst_req_err: got %0h want 0", req_err); end
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %0h want 0", busy); end
        n_tests++; if (grant_id !== 3'd0) begin n_fail++; $display("FAIL rst_grant_id: got %0d want 0", grant_id); end
        n_tests++; if (awaddr !== 64'h0) begin n_fail++; $display("FAIL rst_awaddr: got %h want 0", awaddr); end
        n_tests++; if (wdata !== 64'h0) begin n_fail++; $display("FAIL rst_wdata: got %h want 0", wdata); end
        n_tests++; if (wstrb !== 8'hFF) begin n_fail++; $display("FAIL rst_wstrb: got %h want ff", wstrb); end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_single();
        awready = 1'b1; wready = 1'b1; bvalid = 1'b1; bresp = 2'b00;
        req_addr[2*AW +: AW] = 64'h4000_0000;
        req_data[2*DW +: DW] = 64'hA5;
        req_valid = 4'b0100;
        tick(); // cycle 1
        n_tests++; if (awvalid !== 1'b1) begin n_fail++; $display("FAIL single_awvalid_c1: got %0h want 1", awvalid); end
        n_tests++; if (wvalid !== 1'b1) begin n_fail++; $display("FAIL single_wvalid_c1: got %0h want 1", wvalid); end
        n_tests++; if (awaddr !== 64'h4000_0000) begin n_fail++; $display("FAIL single_awaddr_c1: got %h want 40000000", awaddr); end
        n_tests++; if (wdata !== 64'hA5) begin n_fail++; $display("FAIL single_wdata_c1: got %h want a5", wdata); end
        n_tests++; if (grant_id !== 3'd2) begin n_fail++; $display("FAIL single_grant_c1: got %0d want 2", grant_id); end
        n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL single_busy_c1: got %0h want 1", busy); end
        tick(); // cycle 2
        n_tests++; if (bready !== 1'b1) begin n_fail++; $display("FAIL single_bready_c2: got %0h want 1", bready); end
        n_tests++; if (awvalid !== 1'b0) begin n_fail++; $display("FAIL single_awvalid_c2: got %0h want 0", awvalid); end
        tick(); // cycle 3
        n_tests++; if (req_done !== 4'b0100) begin n_fail++; $display("FAIL single_done_c3: got %b want 0100", req_done); end
        n_tests++; if (req_err !== 1'b0) begin n_fail++; $display("FAIL single_err_c3: got %0h want 0", req_err); end
        n_tests++; if (bready !== 1'b0) begin n_fail++; $display("FAIL single_bready_c3: got %0h want 0", bready); end
        req_valid = 4'b0000;
        tick(); // cycle 4
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL single_busy_c4: got %0h want 0", busy); end
        n_tests++; if (req_done !== 4'b0000) begin n_fail++; $display("FAIL single_done_c4: got %b want 0000", req_done); end
        tick();
        n_tests++; if (awvalid !== 1'b0) begin n_fail++; $display("FAIL single_idle_awvalid: got %0h want 0", awvalid); end
    endtask

    task automatic test_round_robin();
        int cnt[N];
        logic [3:0] exp_oh;
        logic [2:0] exp_g;
        do_reset();
        for (int i = 0; i < N; i++) begin
            cnt[i] = 0;
            req_addr[i*AW +: AW] = 64'h1000 * (i + 1);
            req_data[i*DW +: DW] = 64'h10 + i;
        end
        awready = 1'b1; wready = 1'b1; bvalid = 1'b1; bresp = 2'b00;
        req_valid = 4'b1111;
        for (int n = 0; n < 6; n++) begin
            exp_g  = 3'(n % 4);
            exp_oh = 4'b0001 << (n % 4);
            tick(); // cycle 1
            for (int i = 0; i < N; i++) if (req_done[i]) cnt[i]++;
            n_tests++; if (grant_id !== exp_g) begin n_fail++; $display("FAIL rr_grant_%0d: got %0d want %0d", n, grant_id, exp_g); end
            n_tests++; if (awaddr !== 64'h1000 * (n % 4 + 1)) begin n_fail++; $display("FAIL rr_awaddr_%0d: got %h want %h", n, awaddr, 64'h1000 * (n % 4 + 1)); end
            tick(); // cycle 2
            for (int i = 0; i < N; i++) if (req_done[i]) cnt[i]++;
            tick(); // cycle 3
            for (int i = 0; i < N; i++) if (req_done[i]) cnt[i]++;
            n_tests++; if (req_done !== exp_oh) begin n_fail++; $display("FAIL rr_done_%0d: got %b want %b", n, req_done, exp_oh); end
            tick(); // next IDLE
            for (int i = 0; i < N; i++) if (req_done[i]) cnt[i]++;
            if (n == 3) begin
                for (int i = 0; i < N; i++) begin
                    n_tests++; if (cnt[i] != 1) begin n_fail++; $display("FAIL rr_window_req%0d: got %0d pulses want 1", i, cnt[i]); end
                end
            end
        end
        req_valid = 4'b0000;
        n_tests++; if (cnt[0] != 2 || cnt[1] != 2 || cnt[2] != 1 || cnt[3] != 1) begin
            n_fail++; $display("FAIL rr_totals: got %0d %0d %0d %0d want 2 2 1 1", cnt[0], cnt[1], cnt[2], cnt[3]);
        end
        tick();
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rr_idle_busy: got %0h want 0", busy); end
    endtask

    task automatic test_split();
        awready = 1'b1; wready = 1'b0; bvalid = 1'b1; bresp = 2'b00;
        req_addr[1*AW +: AW] = 64'h2000_0080;
        req_data[1*DW +: DW] = 64'hDEAD_BEEF;
        req_valid = 4'b0010;
        tick(); // cycle 1
        n_tests++; if (awvalid !== 1'b1 || wvalid !== 1'b1) begin n_fail++; $display("FAIL split_valid_c1: got aw=%0h w=%0h want 1 1", awvalid, wvalid); end
        n_tests++; if (grant_id !== 3'd1) begin n_fail++; $display("FAIL split_grant_c1: got %0d want 1", grant_id); end
        req_data[1*DW +: DW] = 64'h1234_5678; // must not leak into the in-flight write
        tick(); // cycle 2
        n_tests++; if (awvalid !== 1'b0) begin n_fail++; $display("FAIL split_awvalid_c2: got %0h want 0", awvalid); end
        n_tests++; if (wvalid !== 1'b1) begin n_fail++; $display("FAIL split_wvalid_c2: got %0h want 1", wvalid); end
        n_tests++; if (wdata !== 64'hDEAD_BEEF) begin n_fail++; $display("FAIL split_wdata_c2: got %h want deadbeef", wdata); end
        n_tests++; if (bready !== 1'b0) begin n_fail++; $display("FAIL split_bready_c2: got %0h want 0", bready); end
        tick(); // cycle 3
        n_tests++; if (wvalid !== 1'b1) begin n_fail++; $display("FAIL split_wvalid_c3: got %0h want 1", wvalid); end
        n_tests++; if (bready !== 1'b0) begin n_fail++; $display("FAIL split_bready_c3: got %0h want 0", bready); end
        tick(); // cycle 4
        n_tests++; if (wvalid !== 1'b1 || wdata !== 64'hDEAD_BEEF) begin n_fail++; $display("FAIL split_w_c4: got v=%0h d=%h want 1 deadbeef", wvalid, wdata); end
        wready = 1'b1;
        tick(); // cycle 5
        n_tests++; if (wvalid !== 1'b0) begin n_fail++; $display("FAIL split_wvalid_c5: got %0h want 0", wvalid); end
        n_tests++; if (bready !== 1'b1) begin n_fail++; $display("FAIL split_bready_c5: got %0h want 1", bready); end
        tick(); // cycle 6
        n_tests++; if (req_done !== 4'b0010) begin n_fail++; $display("FAIL split_done_c6: got %b want 0010", req_done); end
        req_valid = 4'b0000;
        tick();
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL split_busy_end: got %0h want 0", busy); end
    endtask

    task automatic test_error();
        awready = 1'b1; wready = 1'b1; bvalid = 1'b1; bresp = 2'b10;
        req_addr[3*AW +: AW] = 64'h3000;
        req_data[3*DW +: DW] = 64'h33;
        req_valid = 4'b1000;
        tick(); tick();
        n_tests++; if (req_err !== 1'b0) begin n_fail++; $display("FAIL err_early: got %0h want 0", req_err); end
        tick(); // DONE
        n_tests++; if (req_done !== 4'b1000) begin n_fail++; $display("FAIL err_done: got %b want 1000", req_done); end
        n_tests++; if (req_err !== 1'b1) begin n_fail++; $display("FAIL err_flag: got %0h want 1", req_err); end
        bresp = 2'b00;
        tick(); // IDLE, request re-presented
        n_tests++; if (req_err !== 1'b0) begin n_fail++; $display("FAIL err_idle_clear: got %0h want 0", req_err); end
        tick(); tick(); tick(); // ISSUE, RESP, DONE
        n_tests++; if (req_done !== 4'b1000) begin n_fail++; $display("FAIL ok_done: got %b want 1000", req_done); end
        n_tests++; if (req_err !== 1'b0) begin n_fail++; $display("FAIL ok_flag: got %0h want 0", req_err); end
        req_valid = 4'b0000;
        tick();
    endtask

    task automatic test_b_backpressure();
        awready = 1'b1; wready = 1'b1; bvalid = 1'b0; bresp = 2'b00;
        req_valid = 4'b1111;
        tick(); // cycle 1
        n_tests++; if (grant_id !== 3'd0) begin n_fail++; $display("FAIL bp_grant: got %0d want 0", grant_id); end
        tick(); // cycle 2 RESP
        for (int i = 0; i < 6; i++) begin
            n_tests++; if (bready !== 1'b1) begin n_fail++; $display("FAIL bp_bready_%0d: got %0h want 1", i, bready); end
            n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL bp_busy_%0d: got %0h want 1", i, busy); end
            n_tests++; if (awvalid !== 1'b0 || req_done !== 4'b0000) begin n_fail++; $display("FAIL bp_quiet_%0d: got aw=%0h done=%b want 0 0000", i, awvalid, req_done); end
            tick();
        end
        bvalid = 1'b1;
        n_tests++; if (bready !== 1'b1) begin n_fail++; $display("FAIL bp_bready_last: got %0h want 1", bready); end
        tick();
        n_tests++; if (req_done !== 4'b0001) begin n_fail++; $display("FAIL bp_done: got %b want 0001", req_done); end
        req_valid = 4'b0000;
        tick();
    endtask

    task automatic test_async_reset();
        awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = 2'b00;
        req_addr[0*AW +: AW] = 64'hAAA0;
        req_addr[3*AW +: AW] = 64'hBBB0;
        req_valid = 4'b1001;
        tick(); // ISSUE
        n_tests++; if (grant_id !== 3'd3) begin n_fail++; $display("FAIL ar_pre_grant: got %0d want 3", grant_id); end
        tick(); // still ISSUE
        n_tests++; if (awvalid !== 1'b1 || busy !== 1'b1) begin n_fail++; $display("FAIL ar_stall: got aw=%0h busy=%0h want 1 1", awvalid, busy); end
        #2 rst_n = 1'b0;
        #1;
        n_tests++; if (awvalid !== 1'b0 || wvalid !== 1'b0) begin n_fail++; $display("FAIL ar_valids: got aw=%0h w=%0h want 0 0", awvalid, wvalid); end
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL ar_busy: got %0h want 0", busy); end
        n_tests++; if (grant_id !== 3'd0) begin n_fail++; $display("FAIL ar_grant_rst: got %0d want 0", grant_id); end
        #3;
        awready = 1'b1; wready = 1'b1; bvalid = 1'b1;
        rst_n = 1'b1;
        tick(); // ISSUE
        n_tests++; if (grant_id !== 3'd0) begin n_fail++; $display("FAIL ar_post_grant: got %0d want 0", grant_id); end
        n_tests++; if (awaddr !== 64'hAAA0) begin n_fail++; $display("FAIL ar_post_awaddr: got %h want aaa0", awaddr); end
        tick(); tick(); // RESP, DONE
        n_tests++; if (req_done !== 4'b0001) begin n_fail++; $display("FAIL ar_post_done: got %b want 0001", req_done); end
        req_valid = 4'b0000;
        tick();
    endtask

    initial begin
        rst_n = 1'b0; req_valid = '0; req_addr = '0; req_data = '0;
        awready = 1'b0; wready = 1'b0; bresp = 2'b00; bvalid = 1'b0;
        test_reset();
        test_single();
        test_round_robin();
        test_split();
        test_error();
        test_b_backpressure();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
